fpdiv_result_queue: RTL and testbench
=====================================

FPDIV_RESULT_QUEUE -- requirements
Module: fpdiv_result_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of result FIFO entries (power of two, 2..16).
REQ-002 SHALL have port CLOCK, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1, divider result present this cycle.
REQ-005 SHALL have port in_ready, output, 1, queue accepts a result this cycle.
REQ-006 SHALL have port in_opa, input, 32, dividend operand (IEEE-754 single).
REQ-007 SHALL have port in_opb, input, 32, divisor operand (IEEE-754 single).
REQ-008 SHALL have port in_quot, input, 32, raw quotient from the divider.
REQ-009 SHALL have port in_exc_vld, input, 1, in_exc is meaningful; when low, in_exc is ignored.
REQ-010 SHALL have port in_exc, input, 2, divider exception code: 00 divide-by-zero, 01 underflow, 10 overflow, 11 invalid/special.
REQ-011 SHALL have port out_valid, output, 1, head entry valid.
REQ-012 SHALL have port out_ready, input, 1, consumer takes the head entry.
REQ-013 SHALL have port out_result, output, 32, resolved IEEE-754 quotient.
REQ-014 SHALL have port out_flags, output, 4, per-result flags {invalid, divzero, overflow, underflow}.
REQ-015 SHALL have port sticky_flags, output, 4, OR of all flags accepted since last clear.
REQ-016 SHALL have port sticky_clr, input, 1, clears sticky_flags.
REQ-017 SHALL have port done_count, output, 16, number of results popped, modulo 2^16.

Function
REQ-018 Push SHALL occur when in_valid and in_ready are both high; pop SHALL occur when out_valid and out_ready are both high.
REQ-019 in_ready SHALL be high exactly when occupancy < DEPTH; a pop in the same cycle SHALL NOT make a full queue accept a push.
REQ-020 A result pushed in cycle N SHALL appear at out_result with out_valid high in cycle N+1 at the earliest (latency 1, no combinational in-to-out path).
REQ-021 Sign s SHALL equal in_opa[31] XOR in_opb[31] for every resolved result.
REQ-022 With in_exc_vld low, result SHALL be {s, in_quot[30:0]} and flags SHALL be 0000.
REQ-023 Code 00 SHALL give {s,7F800000[30:0]}, flags 0100.
REQ-024 Code 10 SHALL give {s,7F800000[30:0]}, flags 0010; code 01 SHALL give {s,31'b0}, flags 0001.
REQ-025 Code 11 SHALL be resolved from the operands: either NaN, Inf/Inf or 0/0 gives 7FC00000 with flags 1000; Inf/finite-or-zero gives {s,Inf} with flags 0000; finite/Inf gives {s,0} with flags 0000.
REQ-026 Simultaneous push and pop at occupancy 1..DEPTH-1 SHALL leave occupancy unchanged and preserve FIFO order.
REQ-027 Pop from empty and push into full SHALL be impossible by handshake; read and write pointers SHALL wrap modulo DEPTH.
REQ-028 sticky_flags SHALL OR in the flags of each pushed result; sticky_clr SHALL clear them in the next cycle; with clear and push in the same cycle, the pushed flags SHALL survive.
REQ-029 done_count SHALL increment by 1 on each pop and wrap from FFFF to 0000.
REQ-030 out_result and out_flags SHALL hold stable while out_valid is high and out_ready is low.

Reset
REQ-031 When RESET is high at a clock edge, occupancy, pointers, sticky_flags and done_count SHALL be 0, out_valid SHALL be 0, and in_ready SHALL be 1 in the following cycle.
REQ-032 RESET SHALL override a concurrent push, pop or sticky_clr; entries in flight SHALL be discarded.
REQ-033 out_result and out_flags SHALL read 0 while the queue is empty after reset.

Structure
REQ-034 Package fpdiv_pkg SHALL hold QNAN (7FC00000), INF_MAG (7F800000), the exception code constants and the flag bit indices.
REQ-035 Special-value resolution SHALL be one combinational sub-module, fpdiv_fixup; the FIFO, counters and sticky logic SHALL reside in fpdiv_result_queue.

Verification
REQ-036 Push opa=40A00000, opb=40000000, quot=40200000, exc_vld=0 -> next cycle out_result=40200000, flags 0000.
REQ-037 Push opa=40000000, opb=80000000, exc=00 -> out_result=FF800000, flags 0100, sticky bit divzero set.
REQ-038 Push exc=11 for each pair: opa=7F800000/opb=7F800000 -> 7FC00000 (flags 1000); opa=40000000/opb=7F800000 -> 00000000; opa=7F800000/opb=40000000 -> 7F800000.
REQ-039 With out_ready=0, push 4 results -> in_ready=0 after the 4th push; then assert out_ready with in_valid held -> the 4 entries pop in order, the queue refills, and done_count increments by 4.
REQ-040 Preload done_count to FFFF via pops, pop once more -> 0000; assert RESET with 2 entries queued -> out_valid=0, sticky_flags=0 in the next cycle.

Source files
------------

// File: rtl/fpdiv_pkg.sv
// Shared constants and types for the FP divider result queue.
// Holds special encodings, exception codes, flag indices, entry struct.
package fpdiv_pkg;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] INF_MAG = 32'h7F80_0000;

  localparam logic [1:0] EXC_DIVZ    = 2'b00;
  localparam logic [1:0] EXC_UNF     = 2'b01;
  localparam logic [1:0] EXC_OVF     = 2'b10;
  localparam logic [1:0] EXC_SPECIAL = 2'b11;

  // Flag vector layout: {invalid, divzero, overflow, underflow}
  localparam int FLG_INV = 3;
  localparam int FLG_DVZ = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  flags;
  } fpdiv_res_t;

endpackage

// File: rtl/fpdiv_fixup.sv
// Combinational special-value resolution of a raw divider quotient.
// In: opa, opb, quot, exc_vld, exc. Out: res (resolved result + flags).
module fpdiv_fixup
  import fpdiv_pkg::*;
(
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic [31:0] quot,
  input  logic        exc_vld,
  input  logic [1:0]  exc,
  output fpdiv_res_t  res
);

  logic s;
  logic a_max, b_max;
  logic a_mz, b_mz;
  logic a_nan, b_nan, a_inf, b_inf;
  logic a_zero, b_zero;
  logic qnan_c, inf_c, zero_c, dz_c;
  logic unused_q;

  assign s      = opa[31] ^ opb[31];
  assign a_max  = &opa[30:23];
  assign b_max  = &opb[30:23];
  assign a_mz   = ~|opa[22:0];
  assign b_mz   = ~|opb[22:0];
  assign a_nan  = a_max & ~a_mz;
  assign b_nan  = b_max & ~b_mz;
  assign a_inf  = a_max & a_mz;
  assign b_inf  = b_max & b_mz;
  assign a_zero = ~|opa[30:0];
  assign b_zero = ~|opb[30:0];

  // Mutually exclusive special classes, highest precedence first.
  assign qnan_c = a_nan | b_nan
                | (a_inf & b_inf)
                | (a_zero & b_zero);
  assign inf_c  = ~qnan_c & a_inf;
  assign zero_c = ~qnan_c & ~a_inf & b_inf;
  assign dz_c   = ~qnan_c & ~a_inf & ~b_inf
                & b_zero;

  assign unused_q = quot[31];

  always_comb begin
    res.result = {s, quot[30:0]};
    res.flags  = '0;
    if (exc_vld) begin
      unique case (exc)
        EXC_DIVZ: begin
          res.result = {s, INF_MAG[30:0]};
          res.flags[FLG_DVZ] = 1'b1;
        end
        EXC_OVF: begin
          res.result = {s, INF_MAG[30:0]};
          res.flags[FLG_OVF] = 1'b1;
        end
        EXC_UNF: begin
          res.result = {s, 31'b0};
          res.flags[FLG_UNF] = 1'b1;
        end
        EXC_SPECIAL: begin
          unique case (1'b1)
            qnan_c: begin
              res.result = QNAN;
              res.flags[FLG_INV] = 1'b1;
            end
            inf_c:  res.result = {s, INF_MAG[30:0]};
            zero_c: res.result = {s, 31'b0};
            // Finite nonzero / zero flagged as special: treat as x/0.
            dz_c: begin
              res.result = {s, INF_MAG[30:0]};
              res.flags[FLG_DVZ] = 1'b1;
            end
            default: res.result = {s, quot[30:0]};
          endcase
        end
        default: res.flags = '0;
      endcase
    end
  end

endmodule

// File: rtl/fpdiv_result_queue.sv
// Result FIFO for the FP divider: resolves specials on entry, queues.
// Ports: CLOCK/RESET, in_* push side, out_* pop side, sticky, done_count.
module fpdiv_result_queue
  import fpdiv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_opa,
  input  logic [31:0] in_opb,
  input  logic [31:0] in_quot,
  input  logic        in_exc_vld,
  input  logic [1:0]  in_exc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags,
  output logic [3:0]  sticky_flags,
  input  logic        sticky_clr,
  output logic [15:0] done_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  fpdiv_res_t       fix;
  fpdiv_res_t       mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             push, pop;

  fpdiv_fixup u_fixup (
    .opa     (in_opa),
    .opb     (in_opb),
    .quot    (in_quot),
    .exc_vld (in_exc_vld),
    .exc     (in_exc),
    .res     (fix)
  );

  // in_ready ignores a same-cycle pop: no push-through when full.
  assign in_ready  = (count < FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Empty queue presents zeros rather than a stale entry.
  assign out_result = out_valid ? mem[rptr].result : '0;
  assign out_flags  = out_valid ? mem[rptr].flags  : '0;

  always_ff @(posedge CLOCK) begin
    if (push && !RESET) mem[wptr] <= fix;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      sticky_flags <= '0;
      done_count   <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // A clear drops old history but never the flags arriving now.
      sticky_flags <= (sticky_clr ? 4'b0 : sticky_flags)
                    | (push ? fix.flags : 4'b0);
      if (pop) done_count <= done_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fpdiv_result_queue.sv
// Directed self-checking bench for fpdiv_result_queue (DEPTH=4).
// Linear stimulus; immediate assertions at each check point.
module tb_fpdiv_result_queue;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        in_valid, in_ready;
  logic [31:0] in_opa, in_opb, in_quot;
  logic        in_exc_vld;
  logic [1:0]  in_exc;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags, sticky_flags;
  logic        sticky_clr;
  logic [15:0] done_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_done = 16'd0;

  always #5 CLOCK = ~CLOCK;

  fpdiv_result_queue #(.DEPTH(4)) dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opa       (in_opa),
    .in_opb       (in_opb),
    .in_quot      (in_quot),
    .in_exc_vld   (in_exc_vld),
    .in_exc       (in_exc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .done_count   (done_count)
  );

  task automatic cyc();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] q,
                       input logic v,
                       input logic [1:0] e);
    in_opa     = a;
    in_opb     = b;
    in_quot    = q;
    in_exc_vld = v;
    in_exc     = e;
  endtask

  // Push one result into an empty queue, check head, pop it.
  task automatic xfer(input string tag,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] q,
                      input logic v,
                      input logic [1:0] e,
                      input logic [31:0] er,
                      input logic [3:0] ef);
    drive(a, b, q, v, e);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_res"}, out_result, er);
    chk({tag, "_flg"}, 32'(out_flags), 32'(ef));
    out_ready = 1'b1;
    cyc();
    exp_done++;
    out_ready = 1'b0;
    chk({tag, "_done"}, 32'(done_count), 32'(exp_done));
    chk({tag, "_empty"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    RESET      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    sticky_clr = 1'b0;
    drive('0, '0, '0, 1'b0, 2'b00);
    cyc();
    cyc();
    RESET = 1'b0;
    chk("rst_ovld", 32'(out_valid), 32'd0);
    chk("rst_irdy", 32'(in_ready), 32'd1);
    chk("rst_res", out_result, 32'd0);
    chk("rst_flg", 32'(out_flags), 32'd0);
    chk("rst_sticky", 32'(sticky_flags), 32'd0);
    chk("rst_done", 32'(done_count), 32'd0);

    // Plain quotient; exception code ignored when exc_vld low.
    xfer("plain", 32'h40A00000, 32'h40000000,
         32'h40200000, 1'b0, 2'b11,
         32'h40200000, 4'b0000);
    xfer("sign", 32'hC0A00000, 32'h40000000,
         32'h40200000, 1'b0, 2'b00,
         32'hC0200000, 4'b0000);
    chk("sticky_none", 32'(sticky_flags), 32'd0);

    xfer("divz", 32'h40000000, 32'h80000000,
         32'h12345678, 1'b1, 2'b00,
         32'hFF800000, 4'b0100);
    chk("sticky_dz", 32'(sticky_flags), 32'h4);

    sticky_clr = 1'b1;
    cyc();
    sticky_clr = 1'b0;
    chk("sticky_clr", 32'(sticky_flags), 32'd0);

    xfer("unf", 32'hBF800000, 32'h3F800000,
         32'h00000001, 1'b1, 2'b01,
         32'h80000000, 4'b0001);
    chk("sticky_unf", 32'(sticky_flags), 32'h1);

    // Clear and push together: new overflow flag survives.
    drive(32'h3F800000, 32'h3F800000, 32'h0, 1'b1, 2'b10);
    in_valid   = 1'b1;
    sticky_clr = 1'b1;
    cyc();
    in_valid   = 1'b0;
    sticky_clr = 1'b0;
    chk("clrpush_sticky", 32'(sticky_flags), 32'h2);
    chk("ovf_res", out_result, 32'h7F800000);
    chk("ovf_flg", 32'(out_flags), 32'h2);
    out_ready = 1'b1;
    cyc();
    exp_done++;
    out_ready = 1'b0;
    chk("ovf_done", 32'(done_count), 32'(exp_done));

    xfer("inf_inf", 32'h7F800000, 32'h7F800000,
         32'h0, 1'b1, 2'b11, 32'h7FC00000, 4'b1000);
    xfer("fin_inf", 32'h40000000, 32'h7F800000,
         32'h0, 1'b1, 2'b11, 32'h00000000, 4'b0000);
    xfer("inf_fin", 32'h7F800000, 32'h40000000,
         32'h0, 1'b1, 2'b11, 32'h7F800000, 4'b0000);
    xfer("zero_zero", 32'h00000000, 32'h80000000,
         32'h0, 1'b1, 2'b11, 32'h7FC00000, 4'b1000);
    xfer("nan_op", 32'h7FC00001, 32'h3F800000,
         32'h0, 1'b1, 2'b11, 32'h7FC00000, 4'b1000);
    xfer("ninf_zero", 32'hFF800000, 32'h00000000,
         32'h0, 1'b1, 2'b11, 32'hFF800000, 4'b0000);

    // Fill to full with consumer stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(32'h3F800000, 32'h3F800000,
            32'h11111111 * k, 1'b0, 2'b00);
      cyc();
    end
    chk("full_irdy", 32'(in_ready), 32'd0);
    chk("full_head", out_result, 32'h11111111);
    drive(32'h3F800000, 32'h3F800000,
          32'h55555555, 1'b0, 2'b00);
    cyc();
    chk("stall_head", out_result, 32'h11111111);
    chk("stall_done", 32'(done_count), 32'(exp_done));

    // Release consumer with producer still pushing.
    out_ready = 1'b1;
    cyc();
    exp_done++;
    chk("rf_irdy", 32'(in_ready), 32'd1);
    chk("rf_h2", out_result, 32'h22222222);
    drive(32'h3F800000, 32'h3F800000,
          32'h55555555, 1'b0, 2'b00);
    cyc();
    exp_done++;
    chk("rf_h3", out_result, 32'h33333333);
    drive(32'h3F800000, 32'h3F800000,
          32'h66666666, 1'b0, 2'b00);
    cyc();
    exp_done++;
    chk("rf_h4", out_result, 32'h44444444);
    drive(32'h3F800000, 32'h3F800000,
          32'h77777777, 1'b0, 2'b00);
    cyc();
    exp_done++;
    in_valid = 1'b0;
    chk("rf_h5", out_result, 32'h55555555);
    chk("rf_done", 32'(done_count), 32'(exp_done));
    cyc();
    exp_done++;
    chk("dr_h6", out_result, 32'h66666666);
    cyc();
    exp_done++;
    chk("dr_h7", out_result, 32'h77777777);
    cyc();
    exp_done++;
    out_ready = 1'b0;
    chk("dr_empty", 32'(out_valid), 32'd0);
    chk("dr_done", 32'(done_count), 32'(exp_done));

    // Stream until done_count reaches FFFF, then wrap.
    drive(32'h3F800000, 32'h3F800000,
          32'h3F800000, 1'b0, 2'b00);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cyc();
    while (exp_done != 16'hFFFF) begin
      cyc();
      exp_done++;
    end
    chk("done_ffff", 32'(done_count), 32'h0000FFFF);
    cyc();
    exp_done++;
    chk("done_wrap", 32'(done_count), 32'h00000000);

    // Queue a second entry carrying divzero, with clear.
    out_ready = 1'b0;
    drive(32'h40000000, 32'h00000000,
          32'h0, 1'b1, 2'b00);
    sticky_clr = 1'b1;
    cyc();
    sticky_clr = 1'b0;
    in_valid   = 1'b0;
    chk("pre_rst_sticky", 32'(sticky_flags), 32'h4);
    chk("pre_rst_vld", 32'(out_valid), 32'd1);

    // Reset beats concurrent push, pop and clear.
    RESET      = 1'b1;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    sticky_clr = 1'b1;
    cyc();
    RESET      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    sticky_clr = 1'b0;
    chk("rst2_ovld", 32'(out_valid), 32'd0);
    chk("rst2_sticky", 32'(sticky_flags), 32'd0);
    chk("rst2_irdy", 32'(in_ready), 32'd1);
    chk("rst2_done", 32'(done_count), 32'd0);
    chk("rst2_res", out_result, 32'd0);
    cyc();
    chk("rst2_hold", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
